apb_requester: RTL and testbench

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester.sv | 150 +++++++++++++++
 tb/tb_apb_requester.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
//
// Buffers simple read/write commands in a small FIFO and replays them, one at
// a time, as APB transfers. Each transfer walks IDLE -> SETUP -> ACCESS -> TURN
// and therefore occupies exactly four cycles. A one-cycle completion pulse
// (rsp_valid) follows every transfer, in command order.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake (ready = buffer not full, not in reset)
//   cmd_write         : 1 = write, 0 = read
//   cmd_addr          : register address       (Amba_Addr_Depth bits)
//   cmd_wdata         : write data             (Amba_Word bits)
//   PADDR, PSEL, PENABLE, PWRITE, PWDATA : APB requester outputs
//   PRDATA            : APB read data, registered by the completer
//   rsp_valid         : completion pulse, one cycle after TURN
//   rsp_write         : direction of the completed transfer
//   rsp_rdata         : read data of the completed transfer, 0 for writes
//   busy              : buffer non-empty or transfer in flight
// -----------------------------------------------------------------------------
module apb_requester #(
    parameter int Amba_Addr_Depth = 20,
    parameter int Amba_Word       = 32,
    parameter int Fifo_Depth      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [Amba_Addr_Depth-1:0] cmd_addr,
    input  logic [Amba_Word-1:0]       cmd_wdata,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Word-1:0]       PWDATA,
    input  logic [Amba_Word-1:0]       PRDATA,
    output logic                       rsp_valid,
    output logic                       rsp_write,
    output logic [Amba_Word-1:0]       rsp_rdata,
    output logic                       busy
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PW = $clog2(Fifo_Depth) + 1;
    localparam int EW = 1 + Amba_Addr_Depth + Amba_Word;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] TURN   = 2'd3;

    // Command buffer storage: {write, addr, wdata} per entry.
    logic [EW-1:0] fifo_mem [Fifo_Depth];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [1:0]    state_reg;
    logic [1:0]    state_next;

    logic [Amba_Addr_Depth-1:0] paddr_reg;
    logic [Amba_Word-1:0]       pwdata_reg;
    logic                       pwrite_reg;

    logic                 rsp_valid_reg;
    logic                 rsp_write_reg;
    logic [Amba_Word-1:0] rsp_rdata_reg;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                   (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);

    // Gating with rst keeps a command offered during reset from being taken.
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    // The head is consumed on the IDLE->SETUP edge only.
    assign pop       = (state_reg == IDLE) && !empty;
    assign head      = fifo_mem[rd_ptr_reg[PW-2:0]];

    // Storage is not reset: entries are only ever read behind the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PW-2:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!empty) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = TURN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pwrite_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end

            // Address, direction and data are latched once and then held
            // through SETUP/ACCESS and beyond until the next transfer.
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
                {pwrite_reg, paddr_reg, pwdata_reg} <= head;
            end

            // The completer registered PRDATA at the end of ACCESS, so it is
            // stable throughout TURN and is captured at the end of TURN.
            rsp_valid_reg <= (state_reg == TURN);
            if (state_reg == TURN) begin
                rsp_write_reg <= pwrite_reg;
                rsp_rdata_reg <= pwrite_reg ? '0 : PRDATA;
            end
        end
    end

    assign PADDR     = paddr_reg;
    assign PWDATA    = pwdata_reg;
    assign PWRITE    = pwrite_reg;
    assign PSEL      = (state_reg == SETUP) || (state_reg == ACCESS);
    assign PENABLE   = (state_reg == ACCESS);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_write = rsp_write_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign busy      = !empty || (state_reg != IDLE);

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
//
// Self-checking bench for apb_requester. A stimulus process issues commands;
// on acceptance the expected response is computed from a plain register-file
// model (writes store, reads return last stored value or 0) and queued. A
// separate monitor pops the queue on every rsp_valid. A small APB completer
// backs the bus; a protocol monitor checks SETUP/ACCESS ordering and spacing.
// -----------------------------------------------------------------------------
module tb_apb_requester;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        busy;

    apb_requester #(
        .Amba_Addr_Depth(20),
        .Amba_Word(32),
        .Fifo_Depth(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .PADDR(PADDR),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .rsp_valid(rsp_valid),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [19:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem  [logic [19:0]];
    logic [31:0] comp_mem [logic [19:0]];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int n_pushed  = 0;
    int n_discard = 0;
    int n_rsp     = 0;

    logic gap_en      = 1'b0;
    logic busy_chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: register-file semantics, evaluated in acceptance order.
    task automatic model_push(input logic w, input logic [19:0] a, input logic [31:0] d);
        exp_t e;
        e.w = w;
        e.a = a;
        if (w) begin
            ref_mem[a] = d;
            e.d = 32'h0;
        end else begin
            e.d = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        end
        sb.push_back(e);
        n_pushed++;
    endtask

    // APB completer: write stored / read data registered at the end of ACCESS.
    always @(posedge clk) begin
        if (PSEL && PENABLE) begin
            if (PWRITE) comp_mem[PADDR] = PWDATA;
            else        PRDATA <= comp_mem.exists(PADDR) ? comp_mem[PADDR] : 32'h0;
        end
    end
    initial PRDATA = 32'h0;

    // Response scoreboard monitor.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: actual rsp_write=%0b rdata=%0h required=no response", rsp_write, rsp_rdata);
            end else begin
                mon_e = sb.pop_front();
                n_rsp++;
                $display("rsp %0d: addr=%0h write=%0b rdata=%08h (cycle %0d)", n_rsp, mon_e.a, rsp_write, rsp_rdata, cyc);
                check("rsp_write", rsp_write, mon_e.w);
                check("rsp_rdata", rsp_rdata, mon_e.d);
            end
        end
        if (busy_chk_en && !rst && !busy) check("busy_low_with_pending", sb.size(), 0);
    end

    // APB protocol monitor.
    logic        prev_psel  = 1'b0;
    logic        prev_setup = 1'b0;
    int          last_setup = -1;
    logic [19:0] s_addr;
    logic [31:0] s_data;
    logic        s_write;
    always @(negedge clk) begin
        if (!gap_en) last_setup = -1;
        if (!rst) begin
            if (PSEL && !PENABLE) begin
                check("setup_after_idle", prev_psel, 1'b0);
                if (gap_en && last_setup >= 0) check("setup_spacing", cyc - last_setup, 4);
                last_setup = cyc;
                s_addr  = PADDR;
                s_data  = PWDATA;
                s_write = PWRITE;
            end
            if (PSEL && PENABLE) begin
                check("access_after_setup", prev_setup, 1'b1);
                check("access_hold", {PWRITE, PADDR, PWDATA}, {s_write, s_addr, s_data});
            end
            check("penable_implies_psel", PENABLE && !PSEL, 1'b0);
        end
        prev_psel  = PSEL;
        prev_setup = PSEL && !PENABLE;
    end

    // Offer a command (called at a negedge) until it is taken; cmd_valid stays
    // high on return so back-to-back calls form a held burst.
    task automatic send(input logic w, input logic [19:0] a, input logic [31:0] d);
        logic done;
        logic r;
        done = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 100 && !done; i++) begin
            r = cmd_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) begin
                done = 1'b1;
                model_push(w, a, d);
            end
        end
        check("send_accepted", done, 1'b1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((sb.size() != 0 || busy) && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("drain_in_time", i < 2000, 1'b1);
        @(negedge clk);
    endtask

    // Isolated command with cycle-exact phase checks.
    task automatic single(input logic w, input logic [19:0] a, input logic [31:0] d,
                          input logic [31:0] rdata_req);
        send(w, a, d);
        cmd_valid = 1'b0;
        check("single_c0_busy", busy, 1'b1);
        check("single_c0_psel", PSEL, 1'b0);
        @(negedge clk);
        check("single_setup", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, w, a});
        if (w) check("single_pwdata", PWDATA, d);
        @(negedge clk);
        check("single_access", {PSEL, PENABLE}, 2'b11);
        @(negedge clk);
        check("single_turn", {PSEL, PENABLE}, 2'b00);
        @(negedge clk);
        check("single_rsp", {rsp_valid, rsp_write, rsp_rdata}, {1'b1, w, rdata_req});
        @(negedge clk);
        check("single_rsp_pulse", rsp_valid, 1'b0);
        check("single_idle_busy", busy, 1'b0);
    endtask

    logic [31:0] coef [1:8];
    int          remaining;
    int          len;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, '0);
        check("reset_rsp", {rsp_valid, rsp_write, rsp_rdata}, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_cmd_ready", cmd_ready, 1'b1);
        busy_chk_en = 1'b1;

        // Single write, then a read of a different preloaded-by-write address.
        single(1'b1, 20'h1, 32'h00ABC123, 32'h0);
        single(1'b1, 20'h40, 32'h12345678, 32'h0);
        single(1'b0, 20'h40, 32'h0, 32'h12345678);
        drain();

        // Held burst of 5 into a 4-deep buffer.
        gap_en = 1'b1;
        for (int i = 0; i < 5; i++)
            send(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), $urandom);
        cmd_valid = 1'b0;
        check("burst_ready_low_when_full", cmd_ready, 1'b0);
        @(negedge clk);
        check("burst_ready_after_pop", cmd_ready, 1'b1);
        drain();
        gap_en = 1'b0;

        // Configure sequence.
        for (int i = 1; i <= 8; i++) begin
            coef[i] = $urandom;
            send(1'b1, 20'(i), coef[i]);
        end
        send(1'b1, 20'h0, 32'h2);
        send(1'b0, 20'h1, 32'h0);
        cmd_valid = 1'b0;
        drain();

        // Reset during ACCESS with two commands still queued.
        busy_chk_en = 1'b0;
        send(1'b0, 20'h1, 32'h0);
        send(1'b0, 20'h2, 32'h0);
        send(1'b0, 20'h3, 32'h0);
        check("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 20'h5;
        cmd_wdata = 32'hDEAD0001;
        @(negedge clk);
        check("abort_psel", PSEL, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready_in_reset", cmd_ready, 1'b0);
        sb.delete();
        n_discard += 3;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("release_ready", cmd_ready, 1'b1);
        check("release_busy", busy, 1'b0);
        repeat (8) @(negedge clk);
        busy_chk_en = 1'b1;

        // FIFO wrap: 3*depth commands in bursts of varying length and gaps.
        remaining = 12;
        while (remaining > 0) begin
            len = $urandom_range(1, 5);
            if (len > remaining) len = remaining;
            for (int i = 0; i < len; i++)
                send(1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), $urandom);
            cmd_valid = 1'b0;
            remaining -= len;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();

        check("end_busy", busy, 1'b0);
        check("end_queue_empty", sb.size(), 0);
        check("end_rsp_count", n_rsp, n_pushed - n_discard);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
